pi_loop_sequencer: RTL

//  Initiator/controller for the PI pipeline (the responder): accepts ADC samples, presents

---
 rtl/pi_loop_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pi_loop_sequencer.sv
// rtl/pi_loop_sequencer.sv - PI loop sequencer: sample accept, pipeline wait, integral commit, DAC output
module pi_loop_sequencer #(
    parameter int INPUT_WIDTH  = 18,
    parameter int OUTPUT_WIDTH = 32,
    parameter int DAC_WIDTH    = 20,
    parameter int PIPE_LATENCY = 4,
    parameter int OUT_SHIFT    = 10
) (
    input  logic                           clk,
    input  logic                           rst_L,
    input  logic                           enable,
    input  logic                           integral_clear,
    input  logic        [OUTPUT_WIDTH-2:0] integral_limit,
    input  logic signed [INPUT_WIDTH-1:0]  setpoint,
    input  logic signed [INPUT_WIDTH-1:0]  sample_data,
    input  logic                           sample_valid,
    output logic                           sample_ready,
    output logic signed [INPUT_WIDTH-1:0]  pipe_setpoint,
    output logic signed [INPUT_WIDTH-1:0]  pipe_actual,
    output logic signed [OUTPUT_WIDTH-1:0] pipe_integral_input,
    input  logic signed [OUTPUT_WIDTH-1:0] pipe_integral_result,
    input  logic signed [OUTPUT_WIDTH-1:0] pipe_pi_result,
    output logic signed [DAC_WIDTH-1:0]    out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           int_sat,
    output logic                           out_sat
);

    localparam int CNT_W = $clog2(PIPE_LATENCY + 1);
    localparam logic signed [OUTPUT_WIDTH-1:0] DAC_MAX =
        {{(OUTPUT_WIDTH-DAC_WIDTH+1){1'b0}}, {(DAC_WIDTH-1){1'b1}}};
    localparam logic signed [OUTPUT_WIDTH-1:0] DAC_MIN = ~DAC_MAX;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_OUTPUT
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic               clear_pending;
    logic               accept;
    logic               commit;
    logic               out_hs;

    logic signed [OUTPUT_WIDTH-1:0] limit_pos;
    logic signed [OUTPUT_WIDTH-1:0] limit_neg;
    logic signed [OUTPUT_WIDTH-1:0] int_clamped;
    logic                           int_clamp_hit;
    logic signed [OUTPUT_WIDTH-1:0] pi_shifted;
    logic signed [DAC_WIDTH-1:0]    out_next;
    logic                           out_sat_hit;

    always_comb begin
        state_next   = state;
        sample_ready = (state == S_IDLE) && enable && rst_L;
        accept       = sample_valid && sample_ready;
        commit       = (state == S_WAIT) && (cnt == '0);
        out_hs       = (state == S_OUTPUT) && out_valid && out_ready;
        case (state)
            S_IDLE:   if (accept) state_next = S_WAIT;
            S_WAIT:   if (commit) state_next = S_OUTPUT;
            S_OUTPUT: if (out_hs) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        if (!enable) state_next = S_IDLE;
    end

    // Anti-windup clamp against a symmetric window; limit is always non-negative
    always_comb begin
        limit_pos     = $signed({1'b0, integral_limit});
        limit_neg     = -limit_pos;
        int_clamped   = pipe_integral_result;
        int_clamp_hit = 1'b0;
        if (pipe_integral_result > limit_pos) begin
            int_clamped   = limit_pos;
            int_clamp_hit = 1'b1;
        end else if (pipe_integral_result < limit_neg) begin
            int_clamped   = limit_neg;
            int_clamp_hit = 1'b1;
        end
    end

    always_comb begin
        pi_shifted  = pipe_pi_result >>> OUT_SHIFT;
        out_next    = pi_shifted[DAC_WIDTH-1:0];
        out_sat_hit = 1'b0;
        if (pi_shifted > DAC_MAX) begin
            out_next    = DAC_MAX[DAC_WIDTH-1:0];
            out_sat_hit = 1'b1;
        end else if (pi_shifted < DAC_MIN) begin
            out_next    = DAC_MIN[DAC_WIDTH-1:0];
            out_sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state               <= S_IDLE;
            cnt                 <= '0;
            clear_pending       <= 1'b0;
            pipe_setpoint       <= '0;
            pipe_actual         <= '0;
            pipe_integral_input <= '0;
            out_data            <= '0;
            out_valid           <= 1'b0;
            int_sat             <= 1'b0;
            out_sat             <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                pipe_setpoint <= setpoint;
                pipe_actual   <= sample_data;
                cnt           <= CNT_W'(PIPE_LATENCY);
            end else if ((state == S_WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end

            if (!enable) begin
                out_valid           <= 1'b0;
                pipe_integral_input <= '0;
                clear_pending       <= 1'b0;
            end else if (commit) begin
                out_valid     <= 1'b1;
                out_data      <= out_next;
                out_sat       <= out_sat_hit;
                clear_pending <= 1'b0;
                // A clear on the commit edge, or one latched during WAIT, beats the result
                if (integral_clear || clear_pending) begin
                    pipe_integral_input <= '0;
                    int_sat             <= 1'b0;
                end else begin
                    pipe_integral_input <= int_clamped;
                    int_sat             <= int_clamp_hit;
                end
            end else begin
                if (out_hs) out_valid <= 1'b0;
                if (integral_clear) begin
                    if (state == S_WAIT) clear_pending       <= 1'b1;
                    else                 pipe_integral_input <= '0;
                end
            end
        end
    end

endmodule
